// File: rtl/dma_master.sv
// dma_master: single-channel memory-to-memory DMA engine.
// Bus master on the M1 slot (copies SIZE words SRC -> DST, read/wait/write per
// word) and bus slave for CPU programming.
// Optional feature: define DMA_IRQ_EN for a registered job-done interrupt with
// an IRQ_ENABLE bit in CTRL[1]; without it irq is tied low and CTRL[1] reads 0.
module dma_master #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              M_req,
    input  logic              M_grant,
    output logic              M_wr,
    output logic [ADDR_W-1:0] M_address,
    output logic [DATA_W-1:0] M_dout,
    input  logic [DATA_W-1:0] M_din,
    input  logic              S_sel,
    input  logic              S_wr,
    input  logic [ADDR_W-1:0] S_address,
    input  logic [DATA_W-1:0] S_din,
    output logic [DATA_W-1:0] S_dout,
    output logic              irq
);

    typedef enum logic [2:0] {IDLE, REQ, READ, WAIT, WRITE, DONE_ST} state_t;

    state_t            state;
    logic [ADDR_W-1:0] src_r, dst_r;   // programmed registers
    logic [CNT_W-1:0]  size_r;
    logic              busy, done;
    logic [ADDR_W-1:0] src, dst;       // working copies for the running job
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] addr_q;
    logic              req_q, wr_q;

    logic [2:0] offset;
    logic       reg_wr, start_acc;

    assign offset    = S_address[2:0];
    assign reg_wr    = S_sel & S_wr;
    // START is a write-1 pulse; a job already in flight swallows it
    assign start_acc = reg_wr && (offset == 3'd3) && S_din[0] && !busy;

    assign M_req     = req_q;
    // a grant lost during WRITE must not produce a bus write
    assign M_wr      = wr_q & M_grant;
    assign M_address = addr_q;
    assign M_dout    = data_q;

    // bits of the slave bus this register map never looks at
    wire unused_bits = ^{S_address[ADDR_W-1:3], S_din[DATA_W-1:ADDR_W]};

`ifdef DMA_IRQ_EN
    logic irq_en, irq_q;
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    // register file writes and the copy FSM; FSM assignments come last so
    // a DONE set beats a simultaneous CPU clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            src_r  <= '0;
            dst_r  <= '0;
            size_r <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            src    <= '0;
            dst    <= '0;
            cnt    <= '0;
            data_q <= '0;
            addr_q <= '0;
            req_q  <= 1'b0;
            wr_q   <= 1'b0;
`ifdef DMA_IRQ_EN
            irq_en <= 1'b0;
            irq_q  <= 1'b0;
`endif
        end else begin
            if (reg_wr && !busy) begin
                case (offset)
                    3'd0:    src_r  <= S_din[ADDR_W-1:0];
                    3'd1:    dst_r  <= S_din[ADDR_W-1:0];
                    3'd2:    size_r <= S_din[CNT_W-1:0];
                    default: ;
                endcase
            end
`ifdef DMA_IRQ_EN
            if (reg_wr && offset == 3'd3) irq_en <= S_din[1];
`endif
            if (reg_wr && offset == 3'd4) begin
                done <= 1'b0;
`ifdef DMA_IRQ_EN
                irq_q <= 1'b0;
`endif
            end

            case (state)
                IDLE: ;
                REQ: begin
                    if (M_grant) begin
                        state  <= READ;
                        addr_q <= src;
                        wr_q   <= 1'b0;
                    end
                end
                READ: begin
                    state <= M_grant ? WAIT : REQ;
                end
                WAIT: begin
                    if (!M_grant) begin
                        state <= REQ;
                    end else begin
                        data_q <= M_din;
                        addr_q <= dst;
                        wr_q   <= 1'b1;
                        state  <= WRITE;
                    end
                end
                WRITE: begin
                    wr_q <= 1'b0;
                    if (!M_grant) begin
                        // word restarts from READ, no pointer update
                        state <= REQ;
                    end else begin
                        src <= src + 1'b1;
                        dst <= dst + 1'b1;
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            state <= DONE_ST;
                            req_q <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
`ifdef DMA_IRQ_EN
                            irq_q <= irq_q | irq_en;
`endif
                        end else begin
                            state  <= READ;
                            addr_q <= src + 1'b1;
                        end
                    end
                end
                DONE_ST: begin
                    // also completes zero-length jobs, which arrive here busy
                    busy  <= 1'b0;
                    done  <= 1'b1;
`ifdef DMA_IRQ_EN
                    irq_q <= irq_q | irq_en;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (start_acc) begin
                src  <= src_r;
                dst  <= dst_r;
                cnt  <= size_r;
                busy <= 1'b1;
                done <= 1'b0;
                if (size_r == '0) begin
                    state <= DONE_ST;
                end else begin
                    state <= REQ;
                    req_q <= 1'b1;
                end
            end
        end
    end

    // registered register read port; idle cycles return 0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            S_dout <= '0;
        end else if (S_sel && !S_wr) begin
            case (offset)
                3'd0:    S_dout <= DATA_W'(src_r);
                3'd1:    S_dout <= DATA_W'(dst_r);
                3'd2:    S_dout <= DATA_W'(size_r);
`ifdef DMA_IRQ_EN
                3'd3:    S_dout <= DATA_W'({irq_en, 1'b0});
`else
                3'd3:    S_dout <= '0;
`endif
                3'd4:    S_dout <= DATA_W'({done, busy});
                default: S_dout <= '0;
            endcase
        end else begin
            S_dout <= '0;
        end
    end

endmodule
